// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// CTRL field positions, FSM state encoding and the divisor clamp helper.
package uart_tx_pkg;

  // Register word offsets (addr_i[9:2]).
  localparam logic [7:0] TXDATA_OFFSET = 8'h00;
  localparam logic [7:0] STATUS_OFFSET = 8'h01;
  localparam logic [7:0] CTRL_OFFSET   = 8'h02;

  // CTRL field positions.
  localparam int CTRL_DIV_LSB    = 0;
  localparam int CTRL_DIV_W      = 16;
  localparam int CTRL_TX_EN_BIT  = 16;
  localparam int CTRL_IRQ_EN_BIT = 17;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  // A divisor of zero would never let a bit end; treat it as one cycle per bit.
  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with an extra pointer bit to tell full from empty.
// A push while full is dropped even when a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int Depth = 8,
  parameter int Width = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int PtrW = $clog2(Depth);

  logic [PtrW:0]      wptr_q, wptr_d;
  logic [PtrW:0]      rptr_q, rptr_d;
  logic [Width-1:0]   mem_q [Depth];
  logic               do_push, do_pop;

  assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                   (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign level_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[PtrW-1:0]];

  // Qualify push/pop against the current occupancy and advance the pointers.
  always_comb begin
    // NOTE: every signal assigned here gets a value on every path first, so no latch is inferred.
    do_push = push_i & ~full_o;
    do_pop  = pop_i & ~empty_o;
    wptr_d  = wptr_q + {{PtrW{1'b0}}, do_push};
    rptr_d  = rptr_q + {{PtrW{1'b0}}, do_pop};
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk_i) begin
    // NOTE: the storage has no reset; stale entries are unreachable once the pointers are cleared.
    if (do_push) mem_q[wptr_q[PtrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_device.sv
// Memory-mapped 8N1 UART transmitter on the simple-system device bus.
// Bus responses are registered one cycle after req_i; a baud FSM drains the
// TX FIFO onto tx_o and a registered level interrupt flags "all sent".
module uart_tx_device
  import uart_tx_pkg::*;
#(
  parameter int          FifoDepth    = 8,
  parameter logic [15:0] DefaultDiv   = 16'd16,
  parameter int          AddressWidth = 32,
  parameter int          DataWidth    = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [3:0]              be_i,
  input  logic [AddressWidth-1:0] addr_i,
  input  logic [DataWidth-1:0]    wdata_i,
  output logic                    rvalid_o,
  output logic [DataWidth-1:0]    rdata_o,
  output logic                    err_o,
  output logic                    tx_o,
  output logic                    irq_o
);

  localparam int LvlW = $clog2(FifoDepth) + 1;

  // Bus response and CTRL register.
  logic                 rvalid_q, rvalid_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [15:0]          div_q, div_d;
  logic                 tx_en_q, tx_en_d;
  logic                 irq_en_q, irq_en_d;
  logic                 irq_q, irq_d;

  // Transmit FSM and datapath.
  tx_state_e            state_q, state_d;
  logic [15:0]          timer_q, timer_d;
  logic [2:0]           idx_q, idx_d;
  logic [7:0]           shift_q, shift_d;
  logic [15:0]          reload;
  logic                 busy, tx_bit;

  // FIFO interface.
  logic                 push, pop;
  logic [7:0]           fifo_rdata;
  logic                 full, empty;
  logic [LvlW-1:0]      level;

  logic [7:0]           word_addr;
  logic [DataWidth-1:0] status_word, ctrl_word;
  logic                 unused_bits;

  assign word_addr   = addr_i[9:2];
  assign unused_bits = ^{addr_i[AddressWidth-1:10], addr_i[1:0],
                         wdata_i[DataWidth-1:18], be_i[3]};
  assign reload      = eff_div(div_q) - 16'd1;

  uart_tx_fifo #(
    .Depth (FifoDepth),
    .Width (8)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i (wdata_i[7:0]),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  // Assemble readable register images.
  always_comb begin
    status_word             = '0;
    status_word[2:0]        = {busy, empty, full};
    status_word[8 +: LvlW]  = level;
    ctrl_word                                     = '0;
    ctrl_word[CTRL_DIV_LSB +: CTRL_DIV_W]         = div_q;
    ctrl_word[CTRL_TX_EN_BIT]                     = tx_en_q;
    ctrl_word[CTRL_IRQ_EN_BIT]                    = irq_en_q;
  end

  // Decode a bus access: response data/error, CTRL updates, FIFO push.
  always_comb begin
    rvalid_d = req_i;
    rdata_d  = '0;
    err_d    = 1'b0;
    push     = 1'b0;
    div_d    = div_q;
    tx_en_d  = tx_en_q;
    irq_en_d = irq_en_q;
    if (req_i) begin
      case (word_addr)
        TXDATA_OFFSET: begin
          if (we_i && be_i[0]) begin
            if (full) err_d = 1'b1;
            else      push  = 1'b1;
          end
        end
        STATUS_OFFSET: begin
          if (!we_i) rdata_d = status_word;
        end
        CTRL_OFFSET: begin
          if (we_i) begin
            if (be_i[0]) div_d[7:0]  = wdata_i[7:0];
            if (be_i[1]) div_d[15:8] = wdata_i[15:8];
            if (be_i[2]) begin
              tx_en_d  = wdata_i[CTRL_TX_EN_BIT];
              irq_en_d = wdata_i[CTRL_IRQ_EN_BIT];
            end
          end else begin
            rdata_d = ctrl_word;
          end
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  // Interrupt is asserted when enabled and everything has been shifted out.
  assign irq_d = irq_en_q & empty & ~busy;

  // Bus response, CTRL and interrupt registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      div_q    <= DefaultDiv;
      tx_en_q  <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      div_q    <= div_d;
      tx_en_q  <= tx_en_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  // FSM state register with bit timer, bit index and shift register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // Next-state logic; the divisor is sampled at every bit boundary.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_en_q && !empty) begin
          state_d = START;
          pop     = 1'b1;
          shift_d = fifo_rdata;
          timer_d = reload;
        end
      end
      START: begin
        if (timer_q == 16'd0) begin
          state_d = DATA;
          idx_d   = 3'd0;
          timer_d = reload;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      DATA: begin
        if (timer_q == 16'd0) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          timer_d = reload;
          if (idx_q == 3'd7) state_d = STOP;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      STOP: begin
        if (timer_q == 16'd0) begin
          if (tx_en_q && !empty) begin
            state_d = START;
            pop     = 1'b1;
            shift_d = fifo_rdata;
            timer_d = reload;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
    endcase
  end

  // Line level and busy flag decoded from the current state.
  always_comb begin
    busy   = (state_q != IDLE);
    tx_bit = 1'b1;
    case (state_q)
      START:   tx_bit = 1'b0;
      DATA:    tx_bit = shift_q[0];
      default: tx_bit = 1'b1;
    endcase
  end

  assign tx_o     = tx_bit;
  assign irq_o    = irq_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_uart_tx_device.sv
// Self-checking bench for uart_tx_device: bus register behaviour plus a
// byte-queue reference model that predicts the 8N1 waveform on tx_o.
module tb_uart_tx_device;

  localparam int FifoDepth = 8;
  localparam logic [7:0] W_TXDATA = 8'h00;
  localparam logic [7:0] W_STATUS = 8'h01;
  localparam logic [7:0] W_CTRL   = 8'h02;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic        we_i  = 1'b0;
  logic [3:0]  be_i  = '0;
  logic [31:0] addr_i  = '0;
  logic [31:0] wdata_i = '0;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        tx_o;
  logic        irq_o;

  int n_checks = 0;
  int n_errors = 0;

  // Bytes the line is expected to carry, oldest first.
  byte unsigned model_q[$];
  // Expected CTRL contents {irq_en, tx_en, div}.
  logic [17:0]  ctrl_m;

  logic [31:0]  rd_v;
  logic         err_v;

  uart_tx_device #(
    .FifoDepth    (FifoDepth),
    .DefaultDiv   (16'd16),
    .AddressWidth (32),
    .DataWidth    (32)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req_i),
    .we_i     (we_i),
    .be_i     (be_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .err_o    (err_o),
    .tx_o     (tx_o),
    .irq_o    (irq_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  // One bus access; the response is sampled on the following falling edge.
  task automatic bus_xfer(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rd, output logic e);
    @(negedge clk_i);
    req_i = 1'b1; we_i = we; be_i = be; addr_i = addr; wdata_i = wdata;
    @(negedge clk_i);
    req_i = 1'b0; we_i = 1'b0; be_i = '0;
    check("rvalid", 32'(rvalid_o), 32'd1);
    rd = rdata_o;
    e  = err_o;
  endtask

  task automatic write_reg(input logic [7:0] word, input logic [3:0] be,
                           input logic [31:0] data, output logic e);
    logic [31:0] rd;
    bus_xfer(1'b1, be, {22'b0, word, 2'b00}, data, rd, e);
    check("wr_rdata_zero", rd, 32'd0);
  endtask

  task automatic read_reg(input logic [7:0] word, output logic [31:0] data, output logic e);
    bus_xfer(1'b0, 4'hF, {22'b0, word, 2'b00}, 32'd0, data, e);
  endtask

  // Check every queued byte appears as a back-to-back 8N1 frame at the given divisor,
  // then check the interrupt lags the return to idle by one cycle.
  task automatic run_frames(input logic [15:0] div, input logic irq_en);
    int           eff;
    int           waited;
    int           glitches;
    logic [9:0]   exp_bits;
    logic [9:0]   obs_bits;
    byte unsigned b;
    eff    = (div == 16'd0) ? 1 : int'(div);
    waited = 0;
    while (tx_o !== 1'b0 && waited < 8) begin
      @(negedge clk_i);
      waited++;
    end
    check("start_seen", 32'(tx_o), 32'd0);
    while (model_q.size() != 0) begin
      b        = model_q.pop_front();
      exp_bits = {1'b1, b, 1'b0};
      obs_bits = '0;
      glitches = 0;
      for (int k = 0; k < 10; k++) begin
        for (int c = 0; c < eff; c++) begin
          if (c == 0) obs_bits[k] = tx_o;
          else if (tx_o !== obs_bits[k]) glitches++;
          @(negedge clk_i);
        end
      end
      check("frame_bits", 32'(obs_bits), 32'(exp_bits));
      check("frame_stable", glitches, 32'd0);
    end
    check("idle_tx", 32'(tx_o), 32'd1);
    check("irq_lag", 32'(irq_o), 32'd0);
    @(negedge clk_i);
    check("irq_level", 32'(irq_o), 32'(irq_en));
  endtask

  // Load n random bytes with the transmitter disabled, then release them.
  task automatic do_round(input logic [15:0] div, input int n);
    logic         e;
    logic [31:0]  rd;
    byte unsigned bv;
    write_reg(W_CTRL, 4'hF, {14'b0, 2'b10, div}, e);
    for (int i = 0; i < n; i++) begin
      bv = byte'($urandom_range(0, 255));
      model_q.push_back(bv);
      write_reg(W_TXDATA, 4'h1, {24'b0, bv}, e);
      check("push_err", 32'(e), 32'd0);
    end
    write_reg(W_CTRL, 4'hF, {14'b0, 2'b11, div}, e);
    run_frames(div, 1'b1);
    read_reg(W_STATUS, rd, e);
    check("round_status", rd, 32'h0000_0002);
  endtask

  initial begin
    logic [31:0]  addr;
    logic [31:0]  wd;
    logic [3:0]   be;
    logic [7:0]   word;
    logic         we;
    byte unsigned bv;

    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    check("por_tx", 32'(tx_o), 32'd1);
    check("por_rvalid", 32'(rvalid_o), 32'd0);
    check("por_irq", 32'(irq_o), 32'd0);

    // Enable the interrupt so reset has something visible to clear.
    write_reg(W_CTRL, 4'hF, 32'h0002_0010, err_v);
    @(negedge clk_i);
    check("irq_idle_on", 32'(irq_o), 32'd1);

    // Asynchronous reset between edges while a read response is showing.
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b0; be_i = 4'hF; addr_i = {22'b0, W_CTRL, 2'b00};
    @(posedge clk_i);
    #2;
    req_i = 1'b0;
    rst_i = 1'b1;
    #1;
    check("arst_rvalid", 32'(rvalid_o), 32'd0);
    check("arst_rdata", rdata_o, 32'd0);
    check("arst_irq", 32'(irq_o), 32'd0);
    check("arst_tx", 32'(tx_o), 32'd1);
    @(negedge clk_i);
    rst_i = 1'b0;
    read_reg(W_STATUS, rd_v, err_v);
    check("reset_status", rd_v, 32'h0000_0002);
    check("reset_status_err", 32'(err_v), 32'd0);
    read_reg(W_CTRL, rd_v, err_v);
    check("reset_ctrl", rd_v, 32'h0000_0010);

    // Back-to-back write then read of CTRL, one request per cycle.
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b1; be_i = 4'hF; addr_i = {22'b0, W_CTRL, 2'b00}; wdata_i = 32'h0000_0005;
    @(negedge clk_i);
    check("b2b_rvalid0", 32'(rvalid_o), 32'd1);
    check("b2b_err0", 32'(err_o), 32'd0);
    we_i = 1'b0;
    @(negedge clk_i);
    req_i = 1'b0;
    check("b2b_rvalid1", 32'(rvalid_o), 32'd1);
    check("b2b_rdata1", rdata_o, 32'h0000_0005);
    @(negedge clk_i);
    check("b2b_rvalid_off", 32'(rvalid_o), 32'd0);

    // Single byte 0xA5 at div=4.
    write_reg(W_CTRL, 4'hF, 32'h0001_0004, err_v);
    model_q.push_back(8'hA5);
    write_reg(W_TXDATA, 4'h1, 32'h0000_00A5, err_v);
    check("a5_push_err", 32'(err_v), 32'd0);
    run_frames(16'd4, 1'b0);
    read_reg(W_STATUS, rd_v, err_v);
    check("a5_status", rd_v, 32'h0000_0002);

    // Overflow with the transmitter disabled.
    write_reg(W_CTRL, 4'hF, 32'h0000_0004, err_v);
    for (int i = 0; i < FifoDepth + 1; i++) begin
      bv = byte'($urandom_range(0, 255));
      if (i < FifoDepth) model_q.push_back(bv);
      write_reg(W_TXDATA, 4'h1, {24'b0, bv}, err_v);
      check("ovf_err", 32'(err_v), (i == FifoDepth) ? 32'd1 : 32'd0);
    end
    write_reg(W_TXDATA, 4'h0, 32'h0000_00FF, err_v);
    check("ovf_be0_err", 32'(err_v), 32'd0);
    read_reg(W_STATUS, rd_v, err_v);
    check("ovf_status", rd_v, 32'h0000_0801);
    write_reg(W_CTRL, 4'hF, 32'h0003_0001, err_v);
    run_frames(16'd1, 1'b1);

    // Back-to-back frames: the fixed case, then randomised divisors and counts.
    do_round(16'd2, 3);
    for (int r = 0; r < 4; r++)
      do_round(16'($urandom_range(0, 5)), $urandom_range(1, FifoDepth));

    // CTRL byte enables.
    write_reg(W_CTRL, 4'hF, 32'h0001_1234, err_v);
    write_reg(W_CTRL, 4'b0001, 32'hFFFF_FF08, err_v);
    read_reg(W_CTRL, rd_v, err_v);
    check("ctrl_be0", rd_v, 32'h0001_1208);
    ctrl_m = 18'h1_1208;
    for (int i = 0; i < 6; i++) begin
      be = 4'($urandom_range(0, 15));
      wd = $urandom();
      if (be[0]) ctrl_m[7:0]   = wd[7:0];
      if (be[1]) ctrl_m[15:8]  = wd[15:8];
      if (be[2]) ctrl_m[17:16] = wd[17:16];
      write_reg(W_CTRL, be, wd, err_v);
      read_reg(W_CTRL, rd_v, err_v);
      check("ctrl_rand", rd_v, 32'(ctrl_m));
    end

    // Unmapped offsets and the benign cases.
    read_reg(8'h03, rd_v, err_v);
    check("bad_0c_err", 32'(err_v), 32'd1);
    check("bad_0c_rdata", rd_v, 32'd0);
    for (int i = 0; i < 6; i++) begin
      word = 8'($urandom_range(3, 255));
      we   = 1'($urandom_range(0, 1));
      addr = ($urandom() & 32'hFFFF_FC00) | {22'b0, word, 2'b00};
      bus_xfer(we, 4'hF, addr, $urandom(), rd_v, err_v);
      check("bad_rand_err", 32'(err_v), 32'd1);
      check("bad_rand_rdata", rd_v, 32'd0);
    end
    read_reg(W_CTRL, rd_v, err_v);
    check("bad_no_side_effect", rd_v, 32'(ctrl_m));
    read_reg(W_TXDATA, rd_v, err_v);
    check("txdata_read", rd_v, 32'd0);
    check("txdata_read_err", 32'(err_v), 32'd0);
    write_reg(W_STATUS, 4'hF, 32'hFFFF_FFFF, err_v);
    check("status_write_err", 32'(err_v), 32'd0);

    // Reset in the middle of data bit 3 of 0x37 (bit 3 is low).
    write_reg(W_CTRL, 4'hF, 32'h0001_0004, err_v);
    write_reg(W_TXDATA, 4'h1, 32'h0000_0037, err_v);
    write_reg(W_TXDATA, 4'h1, 32'h0000_005A, err_v);
    for (int w = 0; w < 8 && tx_o !== 1'b0; w++) @(negedge clk_i);
    check("mid_start_seen", 32'(tx_o), 32'd0);
    repeat (18) @(negedge clk_i);
    check("mid_bit3", 32'(tx_o), 32'd0);
    #2;
    rst_i = 1'b1;
    #1;
    check("mid_rst_tx", 32'(tx_o), 32'd1);
    @(negedge clk_i);
    rst_i = 1'b0;
    read_reg(W_STATUS, rd_v, err_v);
    check("mid_rst_status", rd_v, 32'h0000_0002);
    repeat (4) @(negedge clk_i);
    check("mid_rst_tx_idle", 32'(tx_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
